i2c_cmd_sequencer: RTL and testbench
====================================

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter NEWD_CYC, default 24, clk cycles m_newd is held high per transaction.
REQ-003 SHALL have parameter TIMEOUT, default 4095, clk cycles allowed from m_newd deassert to done before error.
REQ-004 SHALL use one clock and a synchronous, active-high reset; clock and reset ports are named clk and rst.
REQ-005 SHALL have the following ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept command
- cmd_wr  in  1  1=write, 0=read
- cmd_addr  in  7  target address
- cmd_wdata  in  8  write byte (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_wr  out  1  wr bit of completed command
- rsp_addr  out  7  address of completed command
- rsp_rdata  out  8  read byte (0x00 for writes/errors)
- rsp_err  out  1  transaction timed out
- m_newd  out  1  to master newd
- m_wr  out  1  to master wr
- m_addr  out  7  to master addr
- m_wdata  out  8  to master wdata
- m_rdata  in  8  from master rdata
- m_done  in  1  from master done
- busy  out  1  FSM not IDLE
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Function
REQ-006 FIFO SHALL store {wr,addr,wdata}; push when cmd_valid&&cmd_ready; cmd_ready=(level<DEPTH).
REQ-007 Read/write pointers SHALL wrap modulo DEPTH; simultaneous push and pop SHALL leave level unchanged.
REQ-008 FSM states SHALL be IDLE, ISSUE, WAIT_DONE, RESP.
REQ-009 IDLE: if level>0 and rsp_valid==0, pop head, load m_wr/m_addr/m_wdata, set m_newd=1, go ISSUE next cycle.
REQ-010 ISSUE: hold m_newd=1 for exactly NEWD_CYC cycles, then m_newd=0, clear timer, go WAIT_DONE.
REQ-011 m_wr/m_addr/m_wdata SHALL stay stable from ISSUE entry until next IDLE->ISSUE transition.
REQ-012 m_done SHALL be registered (done_q); done_rise=m_done&&!done_q; done_rise in ISSUE SHALL be ignored.
REQ-013 WAIT_DONE: on done_rise capture m_rdata (read) or 0x00 (write), rsp_err=0, go RESP.
REQ-014 WAIT_DONE: if timer reaches TIMEOUT with no done_rise, rsp_rdata=0x00, rsp_err=1, go RESP.
REQ-015 RESP: rsp_valid=1 with rsp_wr/rsp_addr from issued command; held stable until rsp_ready.
REQ-016 rsp_valid&&rsp_ready SHALL clear rsp_valid and return to IDLE same cycle; next issue earliest following cycle.
REQ-017 FIFO pushes SHALL continue in all states; push into a full FIFO SHALL not occur (cmd_ready=0).
REQ-018 busy SHALL be 1 in ISSUE, WAIT_DONE, RESP.
REQ-019 Timer SHALL saturate at TIMEOUT, width $clog2(TIMEOUT+1).

Reset
REQ-020 On rst=1 at clk edge: state IDLE, level 0, pointers 0, m_newd 0, m_wr 0, m_addr 0, m_wdata 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, rsp_wr 0, rsp_addr 0, done_q 0, timer 0, busy 0.
REQ-021 Reset mid-transaction SHALL discard queued and in-flight commands with no response produced.
REQ-022 cmd_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-023 Write: push wr=1,addr=0x15,wdata=0xA5; m_newd high 24 cycles; pulse m_done -> rsp_valid, rsp_wr=1, rsp_addr=0x15, rsp_rdata=0x00, rsp_err=0.
REQ-024 Read: push wr=0,addr=0x15; model returns m_rdata=0x3C with m_done -> rsp_rdata=0x3C, rsp_err=0.
REQ-025 Full: push 5 commands back-to-back with master stalled -> first issued, 4 held, level=4, cmd_ready=0; responses in push order.
REQ-026 Timeout: issue command, never assert m_done -> rsp_err=1 exactly TIMEOUT cycles after m_newd falls, rsp_rdata=0x00.
REQ-027 Backpressure: hold rsp_ready=0 for 50 cycles with 2 queued -> no second m_newd until response accepted; response fields stable.
REQ-028 Reset in WAIT_DONE with 3 queued -> all outputs at reset values next cycle, level=0, no rsp_valid after later m_done.

Source files
------------

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues I2C byte commands in a FIFO, drives them one at a time
// into a byte-level I2C master, and returns one response per command in push order.
module i2c_cmd_sequencer #(
  parameter int DEPTH    = 4,
  parameter int NEWD_CYC = 24,
  parameter int TIMEOUT  = 4095
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_wr,
  input  logic [6:0]               cmd_addr,
  input  logic [7:0]               cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_wr,
  output logic [6:0]               rsp_addr,
  output logic [7:0]               rsp_rdata,
  output logic                     rsp_err,
  output logic                     m_newd,
  output logic                     m_wr,
  output logic [6:0]               m_addr,
  output logic [7:0]               m_wdata,
  input  logic [7:0]               m_rdata,
  input  logic                     m_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(NEWD_CYC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

  state_t        r_state, w_next;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_timer;
  logic          r_done_q;
  logic [15:0]   w_head;
  logic          w_push, w_pop, w_rise, w_newd_end, w_tmo;

  assign cmd_ready  = r_level < LW'(DEPTH);
  assign w_push     = cmd_valid && cmd_ready;
  assign w_pop      = (r_state == IDLE) && (r_level != '0) && !rsp_valid;
  assign w_rise     = m_done && !r_done_q;
  assign w_newd_end = r_cnt == CW'(NEWD_CYC - 1);
  assign w_tmo      = r_timer == TW'(TIMEOUT - 1);
  assign w_head     = r_mem[r_rptr];
  assign busy       = r_state != IDLE;
  assign level      = r_level;

  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_pop ? ISSUE : IDLE;
      ISSUE:     w_next = w_newd_end ? WAIT_DONE : ISSUE;
      WAIT_DONE: w_next = (w_rise || w_tmo) ? RESP : WAIT_DONE;
      RESP:      w_next = rsp_ready ? IDLE : RESP;
      default:   w_next = IDLE;
    endcase
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= {cmd_wr, cmd_addr, cmd_wdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_q  <= 1'b0;
      r_cnt     <= '0;
      r_timer   <= '0;
      m_newd    <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      r_done_q <= m_done;
      if (w_pop) begin
        {m_wr, m_addr, m_wdata} <= w_head;
        m_newd <= 1'b1;
        r_cnt  <= '0;
      end
      if (r_state == ISSUE) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_newd_end) begin
          m_newd  <= 1'b0;
          r_timer <= '0;
        end
      end
      // A completion edge wins over a timeout landing on the same cycle.
      if (r_state == WAIT_DONE) begin
        r_timer <= (r_timer == TW'(TIMEOUT)) ? r_timer : r_timer + 1'b1;
        if (w_rise || w_tmo) begin
          rsp_valid <= 1'b1;
          rsp_wr    <= m_wr;
          rsp_addr  <= m_addr;
          rsp_err   <= !w_rise;
          rsp_rdata <= (w_rise && !m_wr) ? m_rdata : 8'h00;
        end
      end
      if (r_state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: randomized and directed stimulus with a queue scoreboard;
// a behavioural I2C master model answers each issued command from its queued plan.
module tb_i2c_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int NEWD  = 24;
  localparam int TMO   = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_wr, rsp_err;
  logic [6:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic       m_newd, m_wr, m_done;
  logic [6:0] m_addr;
  logic [7:0] m_wdata, m_rdata;
  logic       busy;
  logic [2:0] level;

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(.DEPTH(DEPTH), .NEWD_CYC(NEWD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_newd(m_newd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .busy(busy), .level(level)
  );

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    bit         tmo;
    int         dly;
    logic [7:0] rdata;
    bit         spur;
  } plan_t;

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  plan_t plans[$];
  rsp_t  exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  bit    hold = 1'b0;
  bit    seen = 1'b0;
  rsp_t  s_rsp, e_rsp;
  plan_t mp;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [6:0] addr, input logic [7:0] wdata,
                      input bit tmo, input int dly, input logic [7:0] rdata, input bit spur);
    int    w = 0;
    plan_t p;
    rsp_t  r;
    while (!cmd_ready && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_wait: cmd_ready=0 after %0d cycles, expected 1", w);
      return;
    end
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    p.wr = wr; p.addr = addr; p.wdata = wdata; p.tmo = tmo;
    p.dly = dly; p.rdata = rdata; p.spur = spur;
    plans.push_back(p);
    r.wr = wr; r.addr = addr; r.err = tmo;
    r.rdata = (tmo || wr) ? 8'h00 : rdata;
    exp_q.push_back(r);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || busy || level != 0) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_done", {31'd0, w < 20000}, 32'd1);
  endtask

  // Master model: checks each issue against the next plan, then answers or stays silent.
  initial begin
    int n, k;
    m_done  = 1'b0;
    m_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (m_newd && !rst) begin
        if (plans.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL issue_unexpected: m_newd=1 with addr 0x%0h, expected no issue", m_addr);
          k = 0;
          while (m_newd && k < NEWD + 10) begin
            @(negedge clk);
            k++;
          end
        end else begin
          mp = plans.pop_front();
          chk("issue_fields", {16'd0, m_wr, m_addr, m_wdata}, {16'd0, mp.wr, mp.addr, mp.wdata});
          m_rdata = 8'($urandom);
          n = 1;
          forever begin
            @(negedge clk);
            m_done = mp.spur && n == 3;
            if (!m_newd || n > NEWD + 4) break;
            chk("issue_stable", {16'd0, m_wr, m_addr, m_wdata}, {16'd0, mp.wr, mp.addr, mp.wdata});
            n++;
          end
          m_done = 1'b0;
          chk("newd_len", n, NEWD);
          if (mp.tmo) begin
            k = 0;
            while (!rsp_valid && k < TMO + 20) begin
              @(negedge clk);
              k++;
            end
            chk("timeout_cycles", k, TMO);
          end else begin
            repeat (mp.dly) @(negedge clk);
            m_rdata = mp.rdata;
            m_done  = 1'b1;
            @(negedge clk);
            m_done  = 1'b0;
            m_rdata = 8'($urandom);
          end
        end
      end
    end
  end

  // Response monitor and rsp_ready driver in one process so the handshake is known here.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      rsp_ready = !rst && !hold && ($urandom_range(0, 3) != 0);
      if (rsp_valid && !rst) begin
        if (!seen) begin
          s_rsp.wr = rsp_wr; s_rsp.addr = rsp_addr; s_rsp.rdata = rsp_rdata; s_rsp.err = rsp_err;
          seen = 1'b1;
        end
        if (rsp_ready) begin
          chk("rsp_stable", {15'd0, rsp_wr, rsp_addr, rsp_rdata, rsp_err},
              {15'd0, s_rsp.wr, s_rsp.addr, s_rsp.rdata, s_rsp.err});
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_unexpected: response addr 0x%0h, expected none", rsp_addr);
          end else begin
            e_rsp = exp_q.pop_front();
            chk("rsp_wr", rsp_wr, e_rsp.wr);
            chk("rsp_addr", rsp_addr, e_rsp.addr);
            chk("rsp_rdata", rsp_rdata, e_rsp.rdata);
            chk("rsp_err", rsp_err, e_rsp.err);
          end
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int w, cnt;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_newd", m_newd, 0);
    chk("rst_m_fields", {m_wr, m_addr, m_wdata}, 0);
    chk("rst_rsp", {rsp_valid, rsp_wr, rsp_addr, rsp_rdata, rsp_err}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    push(1'b1, 7'h15, 8'hA5, 1'b0, 5, 8'h77, 1'b0);
    drain();
    push(1'b0, 7'h15, 8'h00, 1'b0, 3, 8'h3C, 1'b1);
    drain();

    push(1'b1, 7'h01, 8'h11, 1'b0, 60, 8'h00, 1'b0);
    push(1'b0, 7'h02, 8'h00, 1'b0, 2, 8'h22, 1'b0);
    push(1'b1, 7'h03, 8'h33, 1'b0, 0, 8'h00, 1'b1);
    push(1'b0, 7'h04, 8'h00, 1'b0, 7, 8'h44, 1'b0);
    push(1'b0, 7'h05, 8'h00, 1'b0, 1, 8'h55, 1'b0);
    chk("full_level", level, 4);
    chk("full_ready", cmd_ready, 0);
    drain();

    push(1'b0, 7'h2A, 8'h00, 1'b1, 0, 8'h99, 1'b0);
    drain();

    hold = 1'b1;
    push(1'b0, 7'h10, 8'h00, 1'b0, 2, 8'hB1, 1'b0);
    push(1'b1, 7'h11, 8'hC2, 1'b0, 0, 8'h00, 1'b0);
    push(1'b0, 7'h12, 8'h00, 1'b0, 4, 8'hD3, 1'b0);
    w = 0;
    while (!rsp_valid && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("bp_rsp_seen", rsp_valid, 1);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (m_newd) cnt++;
    end
    chk("bp_no_newd", cnt, 0);
    chk("bp_level", level, 2);
    chk("bp_rsp_held", rsp_valid, 1);
    hold = 1'b0;
    drain();

    push(1'b1, 7'h20, 8'h5A, 1'b0, 40, 8'h00, 1'b0);
    push(1'b0, 7'h21, 8'h00, 1'b0, 1, 8'h61, 1'b0);
    push(1'b1, 7'h22, 8'h62, 1'b0, 1, 8'h00, 1'b0);
    push(1'b0, 7'h23, 8'h00, 1'b0, 1, 8'h63, 1'b0);
    w = 0;
    while (!m_newd && w < 100) begin
      @(negedge clk);
      w++;
    end
    while (m_newd && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (10) @(negedge clk);
    chk("pre_rst_level", level, 3);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    plans.delete();
    exp_q.delete();
    chk("mid_rst_level", level, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_m", {m_newd, m_wr, m_addr, m_wdata}, 0);
    chk("mid_rst_rsp", {rsp_valid, rsp_wr, rsp_addr, rsp_rdata, rsp_err}, 0);
    rst = 1'b0;
    cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (rsp_valid || m_newd || busy) cnt++;
    end
    chk("no_activity_after_rst", cnt, 0);

    repeat (30) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(1'($urandom), 7'($urandom), 8'($urandom), $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 3) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
